bsg_manycore_link_net_scheduler: RTL and testbench
==================================================

Name: bsg_manycore_link_net_scheduler

Overview:
- Shares one tagged ready/valid link channel between the manycore forward (request) and reverse (return) networks.
- Applies per-net credit flow control so one congested net cannot block the other at the remote buffer.
- Sits in the manycore clock domain, between the manycore link_sif fwd/rev ready/valid streams and a single async-FIFO/bsg_link serializer.
- Arbitrates round-robin among nets that hold a valid packet and at least one credit, then registers the winner onto the shared channel.

Parameters:
- fwd_width_p, 118, forward packet width (bits).
- rev_width_p, 55, reverse packet width (bits).
- credits_p, 8, remote buffer depth per net. Each counter resets to this value. Must be >= 1.
- lg_credits_lp, `BSG_WIDTH(credits_p)`, credit counter width (localparam).
- payload_width_lp, max(fwd_width_p, rev_width_p), shared payload width (localparam).

Ports:
- clk_i  input  1  manycore clock.
- reset_i  input  1  asynchronous, active-high reset.
- fwd_data_i  input  fwd_width_p  forward packet.
- fwd_v_i  input  1  forward valid.
- fwd_ready_o  output  1  forward accept.
- rev_data_i  input  rev_width_p  reverse packet.
- rev_v_i  input  1  reverse valid.
- rev_ready_o  output  1  reverse accept.
- link_data_o  output  payload_width_lp+1  shared channel: {net_tag, payload}. Tag 1 = fwd, 0 = rev. Payload is zero-extended in the MSBs.
- link_v_o  output  1  shared channel valid.
- link_ready_i  input  1  shared channel ready.
- fwd_credit_i  input  1  one-cycle pulse: the remote side freed one fwd slot.
- rev_credit_i  input  1  one-cycle pulse: the remote side freed one rev slot.
- error_o  output  1  sticky credit-overflow flag.

Behaviour:
- Reset (asynchronous, active-high):
  - link_v_o = 0, link_data_o = 0, error_o = 0.
  - fwd_ready_o = rev_ready_o = 0 while reset_i is high.
  - Both credit counters = credits_p.
  - last_grant = fwd, so rev wins the first tie.
- Output stage: a single register (data + valid).
  - slot_free = ~link_v_o | link_ready_i.
- Eligibility: net n is eligible when n_v_i & (credit_n != 0) & slot_free & ~reset_i.
- Arbitration:
  - Only one net eligible: it wins.
  - Both eligible: the net not equal to last_grant wins.
  - last_grant updates only on a grant.
  - No grant leaves last_grant unchanged.
- Handshake:
  - n_ready_o = grant_n. It is combinational from n_v_i, credits and link_ready_i; valid never depends on ready.
  - The transfer occurs on n_v_i & n_ready_o.
  - At most one ready_o is high per cycle.
- Load on the grant edge:
  - link_data_o <= {tag, zero-extended data}, link_v_o <= 1.
  - If there is no grant and link_ready_i & link_v_o, then link_v_o <= 0 and data holds.
  - link_data_o is stable while link_v_o & ~link_ready_i.
- Latency: an input accepted in cycle t appears at link_data_o in cycle t+1. Throughput is 1 packet/cycle when link_ready_i is held high.
- Credit counters, per net:
  - grant only: counter - 1.
  - credit pulse only: counter + 1.
  - both in the same cycle: unchanged.
  - A counter at 0 blocks its net without affecting the other net.
- Credit overflow: a pulse arriving with the counter == credits_p and no same-cycle grant sets error_o (sticky until reset) and leaves the counter saturated at credits_p.
- Reset mid-operation: the in-flight output register is discarded (link_v_o drops asynchronously) and counters return to credits_p. Upstream packets not yet handshaken are not consumed.
- Invariant: no packet is dropped, duplicated or reordered within a net. Inter-net ordering is not preserved.

Test Plan:
- Reset release, both nets idle, link_ready_i = 1 → link_v_o = 0, ready_o = 0, error_o = 0.
- fwd_v_i = rev_v_i = 1 continuously, link_ready_i = 1, credits replenished each cycle → link tags alternate 0,1,0,1…; first word is rev; one word per cycle; data matches, rev zero-extended above bit 54.
- Only fwd valid, no credit returns, credits_p = 8 → exactly 8 words granted, then fwd_ready_o = 0. One fwd_credit_i pulse → exactly one further word.
- fwd credit exhausted, rev valid with credits → rev streams at 1/cycle, unblocked by fwd.
- link_ready_i = 0 for 5 cycles with a word loaded (tag 1, payload 0x3A) → link_data_o stable, both ready_o = 0. Ready raised → word consumed and next grant loads in the same cycle.
- Grant and rev_credit_i in the same cycle at counter = 3 → counter stays 3. rev_credit_i at counter = 8 with no grant → error_o = 1 and remains 1 until reset.

Source files
------------

// File: rtl/bsg_manycore_link_net_scheduler.sv
// Multiplexes the manycore fwd/rev ready/valid networks onto one tagged link channel,
// with independent per-net credit flow control and round-robin arbitration.
module bsg_manycore_link_net_scheduler #(
  parameter  int fwd_width_p      = 118,
  parameter  int rev_width_p      = 55,
  parameter  int credits_p        = 8,
  localparam int lg_credits_lp    = $clog2(credits_p + 1),
  localparam int payload_width_lp = (fwd_width_p > rev_width_p) ? fwd_width_p : rev_width_p
) (
  input  logic                        clk_i,
  input  logic                        reset_i,

  input  logic [fwd_width_p-1:0]      fwd_data_i,
  input  logic                        fwd_v_i,
  output logic                        fwd_ready_o,

  input  logic [rev_width_p-1:0]      rev_data_i,
  input  logic                        rev_v_i,
  output logic                        rev_ready_o,

  output logic [payload_width_lp:0]   link_data_o,
  output logic                        link_v_o,
  input  logic                        link_ready_i,

  input  logic                        fwd_credit_i,
  input  logic                        rev_credit_i,
  output logic                        error_o
);

  localparam logic [lg_credits_lp-1:0] credits_max_lp = lg_credits_lp'(credits_p);
  localparam logic grant_rev_lp = 1'b0;
  localparam logic grant_fwd_lp = 1'b1;

  logic [lg_credits_lp-1:0]  fwd_credits_r, rev_credits_r;
  logic                      last_grant_r;
  logic                      link_v_r;
  logic [payload_width_lp:0] link_data_r;
  logic                      error_r;

  logic slot_free;
  logic fwd_elig, rev_elig;
  logic grant_fwd, grant_rev;
  logic fwd_overflow, rev_overflow;
  logic [payload_width_lp-1:0] fwd_ext, rev_ext;

  assign slot_free = ~link_v_r | link_ready_i;
  assign fwd_elig  = fwd_v_i & (fwd_credits_r != '0) & slot_free & ~reset_i;
  assign rev_elig  = rev_v_i & (rev_credits_r != '0) & slot_free & ~reset_i;

  // On a tie the net that did not win last time gets the slot.
  always_comb begin
    grant_fwd = 1'b0;
    grant_rev = 1'b0;
    if (fwd_elig && rev_elig) begin
      grant_fwd = (last_grant_r == grant_rev_lp);
      grant_rev = (last_grant_r == grant_fwd_lp);
    end else begin
      grant_fwd = fwd_elig;
      grant_rev = rev_elig;
    end
  end

  assign fwd_ready_o = grant_fwd;
  assign rev_ready_o = grant_rev;

  assign fwd_ext = payload_width_lp'(fwd_data_i);
  assign rev_ext = payload_width_lp'(rev_data_i);

  // A return with no matching grant while already full means the remote side over-credited us.
  assign fwd_overflow = fwd_credit_i & ~grant_fwd & (fwd_credits_r == credits_max_lp);
  assign rev_overflow = rev_credit_i & ~grant_rev & (rev_credits_r == credits_max_lp);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      link_v_r    <= 1'b0;
      link_data_r <= '0;
    end else if (grant_fwd) begin
      link_v_r    <= 1'b1;
      link_data_r <= {1'b1, fwd_ext};
    end else if (grant_rev) begin
      link_v_r    <= 1'b1;
      link_data_r <= {1'b0, rev_ext};
    end else if (link_ready_i && link_v_r) begin
      link_v_r    <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_grant_r <= grant_fwd_lp;
    end else if (grant_fwd) begin
      last_grant_r <= grant_fwd_lp;
    end else if (grant_rev) begin
      last_grant_r <= grant_rev_lp;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fwd_credits_r <= credits_max_lp;
    end else if (grant_fwd && !fwd_credit_i) begin
      fwd_credits_r <= fwd_credits_r - 1'b1;
    end else if (fwd_credit_i && !grant_fwd && (fwd_credits_r != credits_max_lp)) begin
      fwd_credits_r <= fwd_credits_r + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rev_credits_r <= credits_max_lp;
    end else if (grant_rev && !rev_credit_i) begin
      rev_credits_r <= rev_credits_r - 1'b1;
    end else if (rev_credit_i && !grant_rev && (rev_credits_r != credits_max_lp)) begin
      rev_credits_r <= rev_credits_r + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      error_r <= 1'b0;
    end else if (fwd_overflow || rev_overflow) begin
      error_r <= 1'b1;
    end
  end

  assign link_v_o    = link_v_r;
  assign link_data_o = link_data_r;
  assign error_o     = error_r;

endmodule

// File: tb/tb_bsg_manycore_link_net_scheduler.sv
// Directed bench for the fwd/rev link scheduler: a cycle table for arbitration plus
// hand sequences for credit exhaustion, back-pressure and credit overflow.
module tb_bsg_manycore_link_net_scheduler;

  localparam int FW = 118;
  localparam int RW = 55;
  localparam int PW = 118;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [FW-1:0] fwd_data_i;
  logic          fwd_v_i;
  logic          fwd_ready_o;
  logic [RW-1:0] rev_data_i;
  logic          rev_v_i;
  logic          rev_ready_o;
  logic [PW:0]   link_data_o;
  logic          link_v_o;
  logic          link_ready_i;
  logic          fwd_credit_i;
  logic          rev_credit_i;
  logic          error_o;

  int testsRun    = 0;
  int testsFailed = 0;

  bsg_manycore_link_net_scheduler #(
    .fwd_width_p(FW),
    .rev_width_p(RW),
    .credits_p  (8)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .fwd_data_i  (fwd_data_i),
    .fwd_v_i     (fwd_v_i),
    .fwd_ready_o (fwd_ready_o),
    .rev_data_i  (rev_data_i),
    .rev_v_i     (rev_v_i),
    .rev_ready_o (rev_ready_o),
    .link_data_o (link_data_o),
    .link_v_o    (link_v_o),
    .link_ready_i(link_ready_i),
    .fwd_credit_i(fwd_credit_i),
    .rev_credit_i(rev_credit_i),
    .error_o     (error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string         name;
    logic          fv, rv, lr, fc, rc;
    logic [FW-1:0] fd;
    logic [RW-1:0] rd;
    logic          expFr, expRr, expLv, expErr;
    logic [PW:0]   expLd;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [PW:0] fwdWord(input logic [FW-1:0] d);
    return {1'b1, d};
  endfunction

  function automatic logic [PW:0] revWord(input logic [RW-1:0] d);
    return {1'b0, 63'd0, d};
  endfunction

  function automatic vec_t mkVec(input string name, input logic fv, rv, lr, fc, rc,
                                 input logic [FW-1:0] fd, input logic [RW-1:0] rd,
                                 input logic expFr, expRr, expLv, expErr,
                                 input logic [PW:0] expLd);
    vec_t v;
    v.name = name; v.fv = fv; v.rv = rv; v.lr = lr; v.fc = fc; v.rc = rc;
    v.fd = fd; v.rd = rd;
    v.expFr = expFr; v.expRr = expRr; v.expLv = expLv; v.expErr = expErr; v.expLd = expLd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [PW:0] act, input logic [PW:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic fv, rv, lr, fc, rc,
                               input logic [FW-1:0] fd, input logic [RW-1:0] rd);
    fwd_v_i = fv; rev_v_i = rv; link_ready_i = lr;
    fwd_credit_i = fc; rev_credit_i = rc;
    fwd_data_i = fd; rev_data_i = rd;
    #1;
  endtask

  task automatic stepClock;
    @(posedge clk_i);
    #1;
  endtask

  // Asserted between edges so the output register must clear without a clock.
  task automatic doReset(input string name);
    fwd_v_i = 1'b1; rev_v_i = 1'b1; link_ready_i = 1'b1;
    fwd_credit_i = 1'b0; rev_credit_i = 1'b0;
    fwd_data_i = '0; rev_data_i = '0;
    reset_i = 1'b1;
    #1;
    checkOutput({name, "_link_v"},    link_v_o,    '0);
    checkOutput({name, "_link_data"}, link_data_o, '0);
    checkOutput({name, "_fwd_ready"}, fwd_ready_o, '0);
    checkOutput({name, "_rev_ready"}, rev_ready_o, '0);
    checkOutput({name, "_error"},     error_o,     '0);
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    fwd_v_i = 1'b0; rev_v_i = 1'b0;
  endtask

  logic [FW-1:0] fd;
  logic [RW-1:0] rd;
  logic [PW:0]   held;
  int            grants;

  initial begin
    logic [FW-1:0] f2, f4;
    logic [RW-1:0] r1, r3;
    f2 = 118'h3F_1234_5678_9ABC_DEF0_1122_3344_5566;
    f4 = 118'h00_0000_0000_0000_0000_0000_0000_00C3;
    r1 = 55'h40_0000_0000_00A5;
    r3 = 55'h7F_FFFF_FFFF_FFFF;

    vecs[0] = mkVec("idle",   0, 0, 1, 0, 0, '0, '0, 0, 0, 0, 0, '0);
    vecs[1] = mkVec("alt0",   1, 1, 1, 0, 1, '1, r1, 0, 1, 1, 0, revWord(r1));
    vecs[2] = mkVec("alt1",   1, 1, 1, 1, 0, f2, '0, 1, 0, 1, 0, fwdWord(f2));
    vecs[3] = mkVec("alt2",   1, 1, 1, 0, 1, '0, r3, 0, 1, 1, 0, revWord(r3));
    vecs[4] = mkVec("alt3",   1, 1, 1, 1, 0, f4, '1, 1, 0, 1, 0, fwdWord(f4));
    vecs[5] = mkVec("drain",  0, 0, 1, 0, 0, '0, '0, 0, 0, 0, 0, fwdWord(f4));

    doReset("rst0");

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].fv, vecs[i].rv, vecs[i].lr, vecs[i].fc, vecs[i].rc, vecs[i].fd, vecs[i].rd);
      checkOutput({vecs[i].name, "_fwd_ready"}, fwd_ready_o, vecs[i].expFr);
      checkOutput({vecs[i].name, "_rev_ready"}, rev_ready_o, vecs[i].expRr);
      stepClock();
      checkOutput({vecs[i].name, "_link_v"},    link_v_o,    vecs[i].expLv);
      checkOutput({vecs[i].name, "_link_data"}, link_data_o, vecs[i].expLd);
      checkOutput({vecs[i].name, "_error"},     error_o,     vecs[i].expErr);
    end

    // fwd alone with no returns: exactly eight words, then blocked.
    doReset("rst1");
    for (int i = 0; i < 10; i++) begin
      fd = FW'(i + 256);
      applyStimulus(1, 0, 1, 0, 0, fd, '0);
      checkOutput($sformatf("exh%0d_fwd_ready", i), fwd_ready_o, (i < 8));
      stepClock();
      checkOutput($sformatf("exh%0d_link_v", i), link_v_o, (i < 8));
      if (i < 8) checkOutput($sformatf("exh%0d_link_data", i), link_data_o, fwdWord(fd));
    end
    fd = FW'(16'hBEEF);
    applyStimulus(1, 0, 1, 1, 0, fd, '0);
    checkOutput("pulse_fwd_ready_same_cycle", fwd_ready_o, 1'b0);
    stepClock();
    applyStimulus(1, 0, 1, 0, 0, fd, '0);
    checkOutput("pulse_fwd_ready_next", fwd_ready_o, 1'b1);
    stepClock();
    checkOutput("pulse_link_data", link_data_o, fwdWord(fd));
    applyStimulus(1, 0, 1, 0, 0, fd, '0);
    checkOutput("pulse_fwd_ready_after", fwd_ready_o, 1'b0);
    stepClock();

    // rev keeps streaming while fwd has no credit.
    for (int i = 0; i < 4; i++) begin
      rd = RW'(i * 7 + 3);
      applyStimulus(1, 1, 1, 0, 0, '1, rd);
      checkOutput($sformatf("revonly%0d_rev_ready", i), rev_ready_o, 1'b1);
      checkOutput($sformatf("revonly%0d_fwd_ready", i), fwd_ready_o, 1'b0);
      stepClock();
      checkOutput($sformatf("revonly%0d_link_data", i), link_data_o, revWord(rd));
    end

    // Back-pressure: reset lands with a word still on the link.
    checkOutput("pre_rst2_link_v", link_v_o, 1'b1);
    doReset("rst2");
    applyStimulus(1, 0, 1, 0, 0, FW'(8'h3A), '0);
    stepClock();
    checkOutput("stall_load", link_data_o, fwdWord(FW'(8'h3A)));
    held = link_data_o;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 0, 0, 0, FW'(8'h55), RW'(8'h66));
      checkOutput($sformatf("stall%0d_fwd_ready", i), fwd_ready_o, 1'b0);
      checkOutput($sformatf("stall%0d_rev_ready", i), rev_ready_o, 1'b0);
      stepClock();
      checkOutput($sformatf("stall%0d_link_v", i), link_v_o, 1'b1);
      checkOutput($sformatf("stall%0d_link_data", i), link_data_o, held);
    end
    applyStimulus(1, 1, 1, 0, 0, FW'(8'h55), RW'(8'h66));
    checkOutput("unstall_rev_ready", rev_ready_o, 1'b1);
    checkOutput("unstall_fwd_ready", fwd_ready_o, 1'b0);
    stepClock();
    checkOutput("unstall_link_data", link_data_o, revWord(RW'(8'h66)));
    checkOutput("unstall_link_v", link_v_o, 1'b1);

    // rev down to three credits, then grant and return in one cycle leaves it at three.
    doReset("rst3");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 1, 0, 0, '0, RW'(i));
      stepClock();
    end
    applyStimulus(0, 1, 1, 0, 1, '0, RW'(99));
    checkOutput("same_cycle_rev_ready", rev_ready_o, 1'b1);
    stepClock();
    grants = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1, 1, 0, 0, '0, RW'(i + 40));
      if (rev_ready_o) grants++;
      stepClock();
    end
    checkOutput("same_cycle_remaining_grants", RW'(grants), RW'(3));

    // Returning a credit to a full counter is an overflow that stays flagged.
    doReset("rst4");
    applyStimulus(0, 0, 1, 0, 1, '0, '0);
    stepClock();
    checkOutput("overflow_error", error_o, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 0, 0, '0, '0);
      stepClock();
      checkOutput($sformatf("overflow_sticky%0d", i), error_o, 1'b1);
    end
    doReset("rst5");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
